// File: rtl/fir_pkg.sv
// Shared sample type, default sizing and lane placement helper for the FIR
// front-end blocks.
package fir_pkg;

  localparam int SampleW      = 16;
  localparam int DefaultLanes = 4;

  typedef logic [SampleW-1:0] sample_t;

  // Bit offset of lane k inside a packed word of lanes that are width bits each.
  function automatic int lane_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/fir_deser_outreg.sv
// Output holding register of the deserializer: loads a finished word, holds it
// while the FIR array stalls, and drops valid once the word is taken.
module fir_deser_outreg
  import fir_pkg::*;
#(
  parameter int Width = SampleW,
  parameter int Lanes = DefaultLanes
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   load,
  input  logic                   ready,
  input  logic [Lanes*Width-1:0] word,
  input  logic [Lanes-1:0]       word_mask,
  input  logic                   word_last,
  output logic                   valid,
  output logic [Lanes*Width-1:0] data,
  output logic [Lanes-1:0]       mask,
  output logic                   last
);

  // Flush wins, then load (which may coincide with the word being taken),
  // then drain; data/mask are left untouched when not loading so the word
  // stays stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      mask  <= '0;
      last  <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= word;
      mask  <= word_mask;
      last  <= word_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_sample_deser.sv
// Serial-to-parallel sample deserializer between the sample FIFO and the
// parallel FIR tap array. Lane 0 of each word holds the oldest sample.
module fir_sample_deser
  import fir_pkg::*;
#(
  parameter int Width = SampleW,
  parameter int Lanes = DefaultLanes
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [Width-1:0]       in_data_i,
  input  logic                   in_last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [Lanes*Width-1:0] out_data_o,
  output logic [Lanes-1:0]       out_mask_o,
  output logic                   out_last_o,
  output logic                   busy_o
);

  localparam int              CntW    = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Lanes - 1);

  logic [CntW-1:0]        cnt;
  logic [Lanes-1:0]       fill;
  logic [Lanes*Width-1:0] word;
  logic [Lanes-1:0]       word_mask;
  logic                   complete;
  logic                   out_free;
  logic                   in_beat;
  logic                   load;

  // A completing sample needs the output slot; any other sample only needs
  // accumulator space, which always exists.
  assign complete   = in_valid_i & ((cnt == LastIdx) | in_last_i);
  assign out_free   = ~out_valid_o | out_ready_i;
  assign in_ready_o = ~complete | out_free;
  assign in_beat    = in_valid_i & in_ready_o & ~clr_i;
  assign load       = in_beat & complete;
  assign busy_o     = (cnt != '0) | out_valid_o;

  // Lane counter: advances per accepted sample, restarts when a word closes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              cnt <= '0;
    else if (clr_i || load)   cnt <= '0;
    else if (in_beat)         cnt <= cnt + CntW'(1);
  end

  // Per-lane accumulator and word assembly. The top lane is only ever filled
  // by the completing sample itself, so it needs no storage.
  for (genvar k = 0; k < Lanes; k++) begin : g_lane
    logic             hit;
    logic [Width-1:0] lane;

    assign hit          = (cnt == CntW'(k));
    assign word_mask[k] = fill[k] | hit;
    assign word[lane_lsb(k, Width) +: Width] = lane;

    if (k < Lanes - 1) begin : g_acc
      logic             fill_q;
      logic [Width-1:0] acc_q;

      // Capture a non-completing sample into its lane and mark the lane full.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          fill_q <= 1'b0;
          acc_q  <= '0;
        end else if (clr_i || load) begin
          fill_q <= 1'b0;
        end else if (in_beat && hit) begin
          fill_q <= 1'b1;
          acc_q  <= in_data_i;
        end
      end

      assign fill[k] = fill_q;
      assign lane    = hit ? in_data_i : (fill_q ? acc_q : '0);
    end else begin : g_top
      assign fill[k] = 1'b0;
      assign lane    = hit ? in_data_i : '0;
    end
  end

  fir_deser_outreg #(
    .Width (Width),
    .Lanes (Lanes)
  ) u_outreg (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .clr       (clr_i),
    .load      (load),
    .ready     (out_ready_i),
    .word      (word),
    .word_mask (word_mask),
    .word_last (in_last_i),
    .valid     (out_valid_o),
    .data      (out_data_o),
    .mask      (out_mask_o),
    .last      (out_last_o)
  );

endmodule

// File: doc/fir_sample_deser.md
Name: fir_sample_deser

Overview:
- Downstream neighbour of the team's synchronous sample FIFO. Pops serial samples from the FIFO read port (valid/ready, one sample per beat).
- Assembles groups of Lanes samples into one wide parallel word for the parallel FIR tap array. Lane 0 holds the oldest sample.
- Supports early termination of a partial group via in_last_i, and a synchronous flush via clr_i.

Parameters:
- Width, 16, bits per sample.
- Lanes, 4, samples per output word; legal range 1..256.
- CntW (localparam), $clog2(Lanes) with a minimum of 1, lane counter width.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- clr_i  input  1  synchronous flush, same function as the FIFO's clr_i
- in_valid_i  input  1  sample valid (FIFO rvalid)
- in_ready_o  output  1  sample accepted this cycle (FIFO rready)
- in_data_i  input  Width  sample (FIFO rdata)
- in_last_i  input  1  this sample closes the current group, even if partial
- out_valid_o  output  1  wide word valid
- out_ready_i  input  1  FIR array accepts word
- out_data_o  output  Lanes*Width  lane k at bits [k*Width +: Width]
- out_mask_o  output  Lanes  bit k set when lane k carries a real sample
- out_last_o  output  1  word was closed by in_last_i
- busy_o  output  1  accumulator holds at least one sample, or out_valid_o is high

Behaviour:
- Reset (rst_ni low, asynchronous):
  - All outputs are 0; out_data_o is all-zero.
  - Lane counter cnt is 0 and accumulator is cleared.
  - in_ready_o is 1 combinationally, because the output slot is free.
- Storage:
  - Accumulator acc holds Lanes-1 samples, with matching per-lane fill bits.
  - Output register holds data, mask and last.
  - cnt runs from 0 to Lanes-1.
- Handshakes:
  - An input beat occurs when in_valid_i and in_ready_o are both high.
  - An output beat occurs when out_valid_o and out_ready_i are both high.
- Definitions:
  - complete = in_valid_i & ((cnt == Lanes-1) | in_last_i).
  - out_free = ~out_valid_o | out_ready_i.
- Ready rule: in_ready_o = ~complete | out_free.
  - in_ready_o never depends on in_ready_o itself.
  - in_ready_o may depend combinationally on in_valid_i, in_last_i and out_ready_i.
- Non-completing input beat:
  - in_data_i is written to acc lane cnt and that lane's fill bit is set.
  - cnt increments.
- Completing input beat:
  - The output register loads acc with in_data_i placed in lane cnt.
  - mask = fill bits | (1 << cnt). Lanes above cnt are zero in data and 0 in mask.
  - out_last_o = in_last_i.
  - cnt returns to 0 and the fill bits clear, in the same cycle.
- Latency: out_valid_o rises the cycle after the completing input beat.
- Throughput: 1 sample per cycle sustained, i.e. one word every Lanes cycles with no bubble.
  - This holds when out_ready_i is high, or goes high in the cycle the next word completes.
- Output beat without a new completing beat: out_valid_o falls next cycle. out_data_o holds its value, which is don't-care once invalid.
- Output beat and completing input beat in the same cycle: the output register reloads and out_valid_o stays 1.
- Output stall: out_valid_o is high and out_ready_i is low.
  - Non-completing beats still accept, so the accumulator keeps filling.
  - A completing beat is held off (in_ready_o = 0) until out_ready_i rises.
  - out_data_o, out_mask_o and out_last_o stay stable while stalled (AXI-style rule).
- in_last_i with cnt == 0: emits a 1-lane word, mask = 1, last = 1.
- in_last_i is ignored when in_valid_i is low.
- Lanes == 1:
  - Every beat is completing and mask is constantly 1.
  - The block acts as a single-stage register slice. acc is elided.
- clr_i (priority over all activity, takes effect at the clock edge):
  - cnt = 0, fill bits = 0, out_valid_o = 0, out_last_o = 0.
  - Any in-flight beat that cycle is dropped; no sample is written.
  - in_ready_o is still driven by the rule above during clr_i. The upstream FIFO is cleared by the same clr_i.
- Reset asserted mid-word: partial contents are discarded, with no word emitted.
- busy_o = (cnt != 0) | out_valid_o, registered-state based.

Decomposition:
- Package fir_pkg holds:
  - SampleW = 16 and the sample_t typedef.
  - DefaultLanes = 4.
  - The lane-index helper function, used to place lane k at [k*Width +: Width].
- One natural sub-module: fir_deser_outreg, the output holding register with load/hold/drain control.
- Accumulator and counter live in the top module.

Test Plan:
- Lanes=4, continuous valid, samples 0x0001..0x0008, out_ready_i=1:
  - Words {0004,0003,0002,0001} then {0008,0007,0006,0005}, mask 4'hF, last 0.
  - in_ready_o high every cycle; first out_valid_o one cycle after sample 4 is accepted.
- Samples 0xA,0xB,0xC with in_last_i on 0xC:
  - Word lanes = {0,C,B,A}, mask 4'h7, out_last_o=1.
  - Next word starts at lane 0.
- Hold out_ready_i=0 while words 1 and 2 arrive:
  - Samples 5,6,7 are accepted; sample 8 sees in_ready_o=0 until out_ready_i rises.
  - Word 1 is stable throughout the stall.
  - Word 2 appears the cycle after the release, with no sample lost.
- Same-cycle output beat and completing input beat:
  - out_valid_o stays 1 across back-to-back words.
  - 100 random words with random out_ready_i match a scoreboard.
- Assert clr_i after 2 samples, then send 0x11..0x14:
  - Exactly one word {14,13,12,11}, mask F; pre-clear samples never appear.
- Lanes=1, and in_last_i with cnt==0:
  - Each sample gives a 1-lane word, mask 1, one cycle latency.
  - Async rst_ni pulse mid-word gives all outputs 0 immediately and busy_o=0.
